// File: rtl/pmem_responder_if.sv
// Line-oriented physical-memory bus between an initiator (master) and the
// pmem_responder (slave). Carries request, write data, completion and error.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         error;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, error
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, error
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency 256-bit line memory responder.
// A request sampled in IDLE is captured, completes with a one-cycle pmem_resp
// exactly LATENCY cycles later, and write data commits at the edge ending the
// resp cycle. Optional protocol/address checking is compiled in when the macro
// PMEM_RESPONDER_ERRCHK_EN is defined; otherwise error is tied low.
module pmem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input logic               clk,
  input logic               rst,
  pmem_responder_if.slave   bus_io
);

  localparam int unsigned Lines = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    resp_q;
  logic [255:0]            rdata_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    is_write_q;
  logic [255:0]            wdata_q;
  logic [255:0]            mem_q [Lines];

  logic                    req;
  logic [DEPTH_LOG2-1:0]   req_idx;

  assign req     = bus_io.pmem_read | bus_io.pmem_write;
  assign req_idx = bus_io.pmem_address[5 +: DEPTH_LOG2];

  // Transaction FSM, storage and registered outputs; reset wipes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      for (int i = 0; i < int'(Lines); i++) mem_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          resp_q <= 1'b0;
          if (req) begin
            idx_q      <= req_idx;
            // Read wins when both are raised; the write is dropped.
            is_write_q <= bus_io.pmem_write & ~bus_io.pmem_read;
            wdata_q    <= bus_io.pmem_wdata;
            cnt_q      <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_q <= StResp;
              resp_q  <= 1'b1;
              if (bus_io.pmem_read) rdata_q <= mem_q[req_idx];
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            resp_q  <= 1'b1;
            if (!is_write_q) rdata_q <= mem_q[idx_q];
          end
        end
        StResp: begin
          // Requests still held here belong to the finishing transaction.
          resp_q  <= 1'b0;
          state_q <= StIdle;
          if (is_write_q) mem_q[idx_q] <= wdata_q;
        end
        default: begin
          state_q <= StIdle;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.pmem_resp  = resp_q;
  assign bus_io.pmem_rdata = rdata_q;

`ifdef PMEM_RESPONDER_ERRCHK_EN
  logic [31:0] addr_q;
  logic        err_q;
  logic        err_now;

  // Flag illegal requests on acceptance and address instability while busy.
  always_comb begin
    err_now = 1'b0;
    if (state_q == StIdle && req) begin
      err_now = (bus_io.pmem_read & bus_io.pmem_write) |
                (bus_io.pmem_address[4:0] != 5'd0) |
                ((bus_io.pmem_address >> (5 + DEPTH_LOG2)) != 32'd0);
    end else if (state_q == StBusy && req) begin
      err_now = bus_io.pmem_address != addr_q;
    end
  end

  // Sticky error flag plus the full accepted address for the stability check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && req) addr_q <= bus_io.pmem_address;
      err_q <= err_q | err_now;
    end
  end

  assign bus_io.error = err_q;
`else
  assign bus_io.error = 1'b0;
`endif

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from first sampled request to resp; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of stored 256-bit lines.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pmem_read  input  1  line read request, held by initiator until resp.
REQ-006 pmem_write  input  1  line write request, held by initiator until resp.
REQ-007 pmem_address  input  32  byte address of line, 32-byte aligned.
REQ-008 pmem_wdata  input  256  write line data.
REQ-009 pmem_resp  output  1  one-cycle completion pulse.
REQ-010 pmem_rdata  output  256  read line data.
REQ-011 error  output  1  sticky protocol/address error flag.

Function
REQ-012 Storage SHALL be 2^DEPTH_LOG2 lines × 256 bits, indexed by pmem_address[5+DEPTH_LOG2-1:5].
REQ-013 FSM states SHALL be IDLE, BUSY, RESP.
REQ-014 IDLE: on an edge sampling pmem_read or pmem_write high, SHALL capture address, op, wdata, load counter with LATENCY-1, and go BUSY; if LATENCY=1, go directly to RESP.
REQ-015 When read and write are both high in IDLE, read SHALL take priority and the write SHALL be discarded.
REQ-016 BUSY: counter SHALL decrement each cycle; at counter=1 SHALL go RESP on the next edge.
REQ-017 With request first high in cycle 0, pmem_resp SHALL be high exactly in cycle LATENCY, for exactly one cycle.
REQ-018 Read: pmem_rdata SHALL present the indexed line during the resp cycle and hold it until the next read response.
REQ-019 Write: captured wdata SHALL be committed to the indexed line at the edge ending the resp cycle; a read of that line issued afterwards SHALL return the new data.
REQ-020 RESP SHALL always return to IDLE; request inputs sampled in the RESP cycle SHALL be ignored (initiator drops request after resp).
REQ-021 Input changes during BUSY SHALL not affect the captured transaction.
REQ-022 Back-to-back: a new request high in the cycle after resp SHALL start a new transaction of LATENCY cycles.

Reset
REQ-023 Asserting rst SHALL immediately force state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, error 0, and clear all storage lines to zero.
REQ-024 rst mid-transaction SHALL abort it: no resp issued, no write committed.
REQ-025 First request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro PMEM_RESPONDER_ERRCHK_EN SHALL compile in error detection.
REQ-027 With it defined, error SHALL set (sticky until rst) on IDLE acceptance of read&write together, pmem_address[4:0]≠0, nonzero address bits above index, or pmem_address changing while BUSY with request high.
REQ-028 Without it, error SHALL be tied 0 and no checking logic built; all other behaviour identical.

Verification
REQ-029 LATENCY=4: write 0xA5 repeated, address 0x40 in cycle 0 -> resp high only cycle 4; subsequent read of 0x40 -> rdata 0xA5…A5 with resp in its cycle 4.
REQ-030 LATENCY=1: read 0x20 after reset -> resp high in cycle 1, rdata all zero.
REQ-031 Back-to-back: write 0x60 data 0x1, then read 0x60 in cycle after resp -> second resp LATENCY cycles later, rdata 0x1.
REQ-032 rst asserted in cycle 2 of write to 0x80 -> no resp; later read 0x80 returns 0.
REQ-033 ERRCHK_EN defined: read at 0x44 -> error rises, stays high through later clean transactions until rst; undefined -> error stays 0.
REQ-034 Read and write both high, address 0xA0 -> read serviced, line 0xA0 unchanged; error=1 only with ERRCHK_EN.
